// File: rtl/controle_jogada_if.sv
// controle_jogada_if: move request, board RAM port and game status of the move controller
interface controle_jogada_if;
  logic       jogar;
  logic [3:0] macro_in;
  logic [3:0] micro_in;
  logic       ram_we;
  logic [1:0] ram_data;
  logic [3:0] ram_addr_macro;
  logic [3:0] ram_addr_micro;
  logic [1:0] ram_q;
  logic [1:0] ram_state;
  logic       pronto;
  logic       jogada_ok;
  logic       erro;
  logic [1:0] jogador_atual;
  logic [3:0] macro_obrigatoria;
  logic       fim_jogo;
  logic [1:0] vencedor;
  modport master (
    output jogar, macro_in, micro_in, ram_q, ram_state,
    input  ram_we, ram_data, ram_addr_macro, ram_addr_micro, pronto, jogada_ok, erro,
           jogador_atual, macro_obrigatoria, fim_jogo, vencedor
  );
  modport slave (
    input  jogar, macro_in, micro_in, ram_q, ram_state,
    output ram_we, ram_data, ram_addr_macro, ram_addr_micro, pronto, jogada_ok, erro,
           jogador_atual, macro_obrigatoria, fim_jogo, vencedor
  );
endinterface

// File: rtl/controle_jogada.sv
// controle_jogada: validates and commits ultimate tic-tac-toe moves, tracks macro results and winner
module controle_jogada (
  input logic        clk,
  input logic        reset,
  controle_jogada_if.slave bus
);
  typedef enum logic [3:0] {IDLE, VALIDA, LEITURA, ESCRITA, ESPERA, AVALIA, ATUALIZA, ERRO, FIM} state_t;
  state_t           state_q;
  logic [3:0]       mac_q, mic_q, obr_q;
  logic [15:0][1:0] res_q;
  logic [1:0]       jog_q, venc_q;
  logic             pronto_q, ok_q, erro_q, we_q, fim_q;
  logic [1:0]       res_d, alvo_d;
  logic             invalido_d, p1_d, p2_d, cheio_d;

  // a line counts only for three equal player marks; a draw entry (11) never matches p
  function automatic logic linha(input logic [15:0][1:0] b, input logic [1:0] p);
    return (b[1] == p && b[2] == p && b[3] == p) || (b[4] == p && b[5] == p && b[6] == p) ||
           (b[7] == p && b[8] == p && b[9] == p) || (b[1] == p && b[4] == p && b[7] == p) ||
           (b[2] == p && b[5] == p && b[8] == p) || (b[3] == p && b[6] == p && b[9] == p) ||
           (b[1] == p && b[5] == p && b[9] == p) || (b[3] == p && b[5] == p && b[7] == p);
  endfunction

  assign invalido_d = mac_q == 4'd0 || mac_q > 4'd9 || mic_q == 4'd0 || mic_q > 4'd9 ||
                      (obr_q != 4'd0 && mac_q != obr_q) || res_q[mac_q] != 2'b00;
  assign res_d      = bus.ram_state != 2'b00 ? bus.ram_state : res_q[mac_q];
  assign alvo_d     = mic_q == mac_q ? res_d : res_q[mic_q];
  assign p1_d       = linha(res_q, 2'b01);
  assign p2_d       = linha(res_q, 2'b10);
  assign cheio_d    = res_q[1] != 2'b00 && res_q[2] != 2'b00 && res_q[3] != 2'b00 &&
                      res_q[4] != 2'b00 && res_q[5] != 2'b00 && res_q[6] != 2'b00 &&
                      res_q[7] != 2'b00 && res_q[8] != 2'b00 && res_q[9] != 2'b00;

  assign bus.ram_we            = we_q;
  assign bus.ram_data          = jog_q;
  assign bus.ram_addr_macro    = mac_q;
  assign bus.ram_addr_micro    = mic_q;
  assign bus.pronto            = pronto_q;
  assign bus.jogada_ok         = ok_q;
  assign bus.erro              = erro_q;
  assign bus.jogador_atual     = jog_q;
  assign bus.macro_obrigatoria = obr_q;
  assign bus.fim_jogo          = fim_q;
  assign bus.vencedor          = venc_q;

  // move FSM; status pulses appear the cycle after the state that produces them
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mac_q    <= '0;
      mic_q    <= '0;
      obr_q    <= '0;
      res_q    <= '0;
      jog_q    <= 2'b01;
      venc_q   <= 2'b00;
      pronto_q <= 1'b1;
      ok_q     <= 1'b0;
      erro_q   <= 1'b0;
      we_q     <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      ok_q   <= 1'b0;
      erro_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.jogar) begin
          mac_q    <= bus.macro_in;
          mic_q    <= bus.micro_in;
          pronto_q <= 1'b0;
          state_q  <= VALIDA;
        end
        VALIDA:  state_q <= invalido_d ? ERRO : LEITURA;
        LEITURA: begin
          we_q    <= bus.ram_q == 2'b00;
          state_q <= bus.ram_q == 2'b00 ? ESCRITA : ERRO;
        end
        ESCRITA: state_q <= ESPERA;
        ESPERA:  state_q <= AVALIA;
        AVALIA: begin
          res_q[mac_q] <= res_d;
          obr_q        <= alvo_d == 2'b00 ? mic_q : 4'd0;
          jog_q        <= ~jog_q;
          ok_q         <= 1'b1;
          state_q      <= ATUALIZA;
        end
        ATUALIZA: begin
          venc_q   <= p1_d ? 2'b01 : p2_d ? 2'b10 : cheio_d ? 2'b11 : 2'b00;
          fim_q    <= p1_d || p2_d || cheio_d;
          pronto_q <= !(p1_d || p2_d || cheio_d);
          state_q  <= p1_d || p2_d || cheio_d ? FIM : IDLE;
        end
        ERRO: begin
          erro_q   <= 1'b1;
          pronto_q <= 1'b1;
          state_q  <= IDLE;
        end
        FIM:     state_q <= FIM;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_controle_jogada.sv
// tb_controle_jogada: directed moves against a board RAM model, scoreboard-checked outputs
module tb_controle_jogada;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  controle_jogada_if bus ();
  controle_jogada dut (.clk(clk), .reset(reset), .bus(bus));

  logic [1:0] mem [0:255] = '{default: 2'b00};
  logic [1:0] st [0:15] = '{default: 2'b00};
  logic [7:0] ra = 8'd0;
  always @(posedge clk) begin
    ra <= {bus.ram_addr_macro, bus.ram_addr_micro};
    if (bus.ram_we) mem[{bus.ram_addr_macro, bus.ram_addr_micro}] <= bus.ram_data;
  end
  assign bus.ram_q     = mem[ra];
  assign bus.ram_state = st[bus.ram_addr_macro];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int k; int t; logic [3:0] m; logic [3:0] u; logic [1:0] d; logic [1:0] j;
    logic [3:0] o; logic p; logic f; logic [1:0] v;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic snap = 1'b0, done = 1'b0;
  string nm [4] = '{"ram_write", "jogada_ok", "erro", "status"};

  function automatic exp_t mk(input int k, input int t, input logic [3:0] m, input logic [3:0] u,
                              input logic [1:0] d, input logic [1:0] j, input logic [3:0] o,
                              input logic p, input logic f, input logic [1:0] v);
    exp_t e;
    e.k = k; e.t = t; e.m = m; e.u = u; e.d = d; e.j = j; e.o = o; e.p = p; e.f = f; e.v = v;
    return e;
  endfunction

  task automatic evt(input int k);
    exp_t e, a;
    logic ok;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event at cycle %0d, none expected", nm[k], cyc);
      return;
    end
    e = q.pop_front();
    a = mk(k, k == 3 ? -1 : cyc, bus.ram_addr_macro, bus.ram_addr_micro, bus.ram_data,
           bus.jogador_atual, bus.macro_obrigatoria, bus.pronto, bus.fim_jogo, bus.vencedor);
    ok = e.k == a.k && e.t == a.t && (k != 0 || {e.m, e.u, e.d} == {a.m, a.u, a.d}) &&
         (k == 0 || {e.j, e.o} == {a.j, a.o}) && (k != 3 || {e.p, e.f, e.v} == {a.p, a.f, a.v});
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d cyc=%0d mac=%0d mic=%0d data=%0d jog=%0d obr=%0d pronto=%0d fim=%0d venc=%0d; need kind=%0d cyc=%0d mac=%0d mic=%0d data=%0d jog=%0d obr=%0d pronto=%0d fim=%0d venc=%0d",
               nm[k], a.k, a.t, a.m, a.u, a.d, a.j, a.o, a.p, a.f, a.v,
               e.k, e.t, e.m, e.u, e.d, e.j, e.o, e.p, e.f, e.v);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ram_we) evt(0);
    if (bus.jogada_ok) evt(1);
    if (bus.erro) evt(2);
    if (snap) evt(3);
    if (done) begin
      n_cmp++;
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL queue_empty: %0d expectations left, need 0", q.size());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(bus.pronto || bus.fim_jogo)) begin
      @(posedge clk) #1;
      if (++n > 40) begin
        $display("FAIL wait_idle: timeout at cycle %0d, need pronto or fim_jogo", cyc);
        $fatal(1);
      end
    end
  endtask

  // k: 0 valid move, 1 rejected in VALIDA, 2 rejected for occupied cell; j/o are the values after the move
  task automatic mover(input logic [3:0] m, input logic [3:0] u, input int k,
                       input logic [1:0] j, input logic [3:0] o);
    int s;
    s = cyc;
    if (k == 0) begin
      q.push_back(mk(0, s + 3, m, u, ~j, 2'b00, 4'd0, 1'b0, 1'b0, 2'b00));
      q.push_back(mk(1, s + 6, 4'd0, 4'd0, 2'b00, j, o, 1'b0, 1'b0, 2'b00));
    end else begin
      q.push_back(mk(2, s + 2 + k, 4'd0, 4'd0, 2'b00, j, o, 1'b0, 1'b0, 2'b00));
    end
    bus.jogar = 1'b1; bus.macro_in = m; bus.micro_in = u;
    @(posedge clk) #1 bus.jogar = 1'b0;
    wait_idle();
  endtask

  task automatic st_chk(input logic p, input logic f, input logic [1:0] v,
                        input logic [1:0] j, input logic [3:0] o);
    q.push_back(mk(3, -1, 4'd0, 4'd0, 2'b00, j, o, p, f, v));
    snap = 1'b1;
    @(posedge clk) #1 snap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    bus.jogar = 1'b0; bus.macro_in = 4'd0; bus.micro_in = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    st_chk(1'b1, 1'b0, 2'b00, 2'b01, 4'd0);
    mover(4'd5, 4'd3, 0, 2'b10, 4'd3);
    mover(4'd4, 4'd2, 1, 2'b10, 4'd3);
    mover(4'd3, 4'd5, 0, 2'b01, 4'd5);
    mover(4'd5, 4'd3, 2, 2'b01, 4'd5);
    mover(4'd4, 4'd1, 1, 2'b01, 4'd5);
    mover(4'd0, 4'd3, 1, 2'b01, 4'd5);
    mover(4'd5, 4'd10, 1, 2'b01, 4'd5);
    st[5] = 2'b01;
    mover(4'd5, 4'd5, 0, 2'b10, 4'd0);
    st[5] = 2'b00;
    mover(4'd5, 4'd1, 1, 2'b10, 4'd0);
    st_chk(1'b1, 1'b0, 2'b00, 2'b10, 4'd0);
    reset = 1'b1;
    @(posedge clk) #1 reset = 1'b0;
    st_chk(1'b1, 1'b0, 2'b00, 2'b01, 4'd0);
    mover(4'd2, 4'd1, 0, 2'b10, 4'd1);
    st[1] = 2'b10;
    mover(4'd1, 4'd5, 0, 2'b01, 4'd5);
    mover(4'd5, 4'd1, 0, 2'b10, 4'd0);
    st[5] = 2'b10;
    mover(4'd5, 4'd9, 0, 2'b01, 4'd9);
    mover(4'd9, 4'd1, 0, 2'b10, 4'd0);
    st[9] = 2'b10;
    mover(4'd9, 4'd4, 0, 2'b01, 4'd4);
    st_chk(1'b0, 1'b1, 2'b10, 2'b01, 4'd4);
    bus.jogar = 1'b1; bus.macro_in = 4'd2; bus.micro_in = 4'd3;
    repeat (4) @(posedge clk);
    #1 bus.jogar = 1'b0;
    st_chk(1'b0, 1'b1, 2'b10, 2'b01, 4'd4);
    reset = 1'b1;
    @(posedge clk) #1 reset = 1'b0;
    st_chk(1'b1, 1'b0, 2'b00, 2'b01, 4'd0);
    s = cyc;
    q.push_back(mk(0, s + 3, 4'd7, 4'd7, 2'b01, 2'b00, 4'd0, 1'b0, 1'b0, 2'b00));
    bus.jogar = 1'b1; bus.macro_in = 4'd7; bus.micro_in = 4'd7;
    @(posedge clk) #1 bus.jogar = 1'b0;
    repeat (2) @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1 reset = 1'b0;
    st_chk(1'b1, 1'b0, 2'b00, 2'b01, 4'd0);
    st[1] = 2'b11; st[2] = 2'b01; st[3] = 2'b10; st[4] = 2'b01; st[5] = 2'b11;
    st[6] = 2'b10; st[7] = 2'b10; st[8] = 2'b01; st[9] = 2'b11;
    mover(4'd1, 4'd1, 0, 2'b10, 4'd0);
    mover(4'd2, 4'd2, 0, 2'b01, 4'd0);
    mover(4'd3, 4'd3, 0, 2'b10, 4'd0);
    mover(4'd4, 4'd4, 0, 2'b01, 4'd0);
    mover(4'd6, 4'd6, 0, 2'b10, 4'd0);
    mover(4'd5, 4'd6, 0, 2'b01, 4'd0);
    mover(4'd7, 4'd1, 0, 2'b10, 4'd0);
    mover(4'd8, 4'd8, 0, 2'b01, 4'd0);
    mover(4'd9, 4'd9, 0, 2'b10, 4'd0);
    st_chk(1'b0, 1'b1, 2'b11, 2'b10, 4'd0);
    done = 1'b1;
    @(posedge clk) #1 done = 1'b0;
    @(posedge clk) #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
